brf_ec: RTL and testbench
=========================

BRF_EC -- requirements
Module: brf_ec

Interface
REQ-001: Parameter LCWIDTH, default 16, loop-counter width in bits.
REQ-002: Parameter ECWIDTH, default 4, epilogue-counter width in bits.
REQ-003: clk  input  1  sole clock; all state updates on rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: enable  input  1  unit enable; qualifies op.
REQ-006: running  input  1  controller running flag; qualifies op.
REQ-007: op  input  1  branch op pulse at cycle II-1 of each iteration.
REQ-008: load  input  1  one-cycle pulse; latch lc_in/ec_in and start a loop.
REQ-009: lc_in  input  LCWIDTH  initial loop count (kernel iterations remaining after the first).
REQ-010: ec_in  input  ECWIDTH  initial epilogue stage count.
REQ-011: p  output  1  registered stage predicate for the next iteration.
REQ-012: p_enable  output  1  registered one-cycle strobe; p is valid.
REQ-013: taken  output  1  registered; loop-back branch taken.
REQ-014: lc_out  output  LCWIDTH  registered current loop count.
REQ-015: lc_enable  output  1  registered one-cycle strobe; lc_out was written.
REQ-016: ec_out  output  ECWIDTH  registered current epilogue count.
REQ-017: ec_enable  output  1  registered one-cycle strobe; ec_out was written.
REQ-018: busy  output  1  high in KERNEL or EPILOGUE.
REQ-019: done  output  1  one-cycle pulse on loop completion.
REQ-020: err  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-021: brf_cycle SHALL be op & enable & running; all counter updates occur only on clock edges where brf_cycle or load is high.
REQ-022: States SHALL be IDLE, KERNEL, EPILOGUE, DONE; busy = (KERNEL|EPILOGUE), decoded from the state register.
REQ-023: IDLE/DONE with load: lc_out<=lc_in, ec_out<=ec_in, next state KERNEL; no strobes asserted.
REQ-024: KERNEL, brf_cycle, lc_out>0: lc_out<=lc_out-1 (modulo 2^LCWIDTH, carry discarded), p=1, taken=1, lc_enable=1, ec_enable=0; stay KERNEL.
REQ-025: KERNEL, brf_cycle, lc_out==0, ec_out>1: ec_out<=ec_out-1, p=0, taken=1, lc_enable=1 (rewrite of 0), ec_enable=1; go EPILOGUE.
REQ-026: KERNEL, brf_cycle, lc_out==0, ec_out<=1: ec_out<=0, p=0, taken=0, lc_enable=1, ec_enable=1; go DONE.
REQ-027: EPILOGUE, brf_cycle, ec_out>1: ec_out<=ec_out-1, p=0, taken=1, ec_enable=1, lc_enable=0; stay EPILOGUE.
REQ-028: EPILOGUE, brf_cycle, ec_out==1: ec_out<=0, p=0, taken=0, ec_enable=1; go DONE.
REQ-029: p_enable SHALL pulse for exactly one cycle, the cycle after every brf_cycle taken in KERNEL or EPILOGUE; latency 1 clock for all strobes and values.
REQ-030: Strobes (p_enable, lc_enable, ec_enable) SHALL be 0 in every cycle not following an accepted brf_cycle; p and taken SHALL be 0 whenever p_enable is 0.
REQ-031: done SHALL be high for exactly the one cycle the state register holds DONE; DONE SHALL go to IDLE on the next edge unless load is high (then KERNEL).
REQ-032: brf_cycle in IDLE or DONE SHALL be ignored; counters and strobes unchanged.
REQ-033: load in KERNEL or EPILOGUE SHALL be ignored; a simultaneous brf_cycle SHALL be processed normally.
REQ-034: enable or running low SHALL freeze the loop (state and counters hold) without clearing.

Reset
REQ-035: On reset high at a clock edge: state IDLE; p, p_enable, taken, lc_enable, ec_enable, busy, done, err = 0; lc_out = 0; ec_out = 0.
REQ-036: Reset SHALL override load and brf_cycle in the same cycle, including mid-KERNEL or mid-EPILOGUE.

Configuration
REQ-037: Macro BRF_EC_ERR_CHECK_EN defined: err SHALL set (sticky until reset) on the edge after brf_cycle in IDLE/DONE or load in KERNEL/EPILOGUE; the event itself is still ignored per REQ-032/033.
REQ-038: Macro BRF_EC_ERR_CHECK_EN undefined: err SHALL be constant 0 and no error-detection logic synthesised.

Verification
REQ-039: load lc_in=3, ec_in=1; 4 brf_cycles -> p=1,1,1,0; taken=1,1,1,0; lc_out=2,1,0,0; done pulses after 4th; busy low after.
REQ-040: load lc_in=2, ec_in=3; 5 brf_cycles -> p=1,1,0,0,0; taken=1,1,1,1,0; ec_out=3,3,2,1,0; EPILOGUE entered after 3rd.
REQ-041: load lc_in=0, ec_in=0; 1 brf_cycle -> p=0, taken=0, lc_enable=1, ec_enable=1, done next cycle.
REQ-042: load lc_in=5, ec_in=2; op pulses with running=0 for 3 cycles -> no strobes, lc_out stays 5; then running=1 resumes at lc_out=4.
REQ-043: load lc_in=4, ec_in=2; reset asserted after 2nd brf_cycle -> all outputs 0 next cycle, state IDLE; subsequent op ignored.
REQ-044: With BRF_EC_ERR_CHECK_EN: op in IDLE -> err=1 next cycle, held until reset; without macro err stays 0.

Source files
------------

// File: rtl/brf_ec_if.sv
`default_nettype none
// ============================================================================
//  Module      : brf_ec_if
//  Description : Handshake/bus bundle for the brf_ec loop-branch unit.
//                master : controller side, drives enable/running/op/load and
//                         the initial counter values, observes the results.
//                slave  : the brf_ec unit itself.
//  Ports       : enable, running, op, load, lc_in, ec_in   (master -> slave)
//                p, p_enable, taken, lc_out, lc_enable,
//                ec_out, ec_enable, busy, done, err        (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface brf_ec_if #(
  parameter int LCWIDTH = 16,
  parameter int ECWIDTH = 4
);
  logic               enable;
  logic               running;
  logic               op;
  logic               load;
  logic [LCWIDTH-1:0] lc_in;
  logic [ECWIDTH-1:0] ec_in;
  logic               p;
  logic               p_enable;
  logic               taken;
  logic [LCWIDTH-1:0] lc_out;
  logic               lc_enable;
  logic [ECWIDTH-1:0] ec_out;
  logic               ec_enable;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output enable, running, op, load, lc_in, ec_in,
    input  p, p_enable, taken, lc_out, lc_enable, ec_out, ec_enable,
           busy, done, err
  );

  modport slave (
    input  enable, running, op, load, lc_in, ec_in,
    output p, p_enable, taken, lc_out, lc_enable, ec_out, ec_enable,
           busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/brf_ec.sv
`default_nettype none
// ============================================================================
//  Module      : brf_ec
//  Description : Modulo-scheduled loop branch unit with loop counter (LC) and
//                epilogue counter (EC). Each accepted branch op decrements LC
//                through the kernel, then EC through the epilogue, producing
//                the stage predicate p and the loop-back decision taken.
//  Ports       : clk   - sole clock, rising edge
//                reset - synchronous active-high reset
//                bus   - brf_ec_if.slave (controls, counter loads, results)
//  Options     : BRF_EC_ERR_CHECK_EN - when defined, err becomes a sticky
//                protocol-error flag (op in IDLE/DONE, load while busy);
//                when undefined err is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module brf_ec #(
  parameter int LCWIDTH = 16,
  parameter int ECWIDTH = 4
) (
  input  wire logic  clk,
  input  wire logic  reset,
  brf_ec_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_KERNEL   = 2'd1,
    ST_EPILOGUE = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [LCWIDTH-1:0] r_lc, w_lc_nxt;
  logic [ECWIDTH-1:0] r_ec, w_ec_nxt;
  logic               r_p, w_p_nxt;
  logic               r_taken, w_taken_nxt;
  logic               r_p_en, w_p_en_nxt;
  logic               r_lc_en, w_lc_en_nxt;
  logic               r_ec_en, w_ec_en_nxt;
  logic               w_brf_cycle;

  assign w_brf_cycle = bus.op & bus.enable & bus.running;

  // Next-state and next-output logic. Every output is registered, so the
  // values computed here appear one clock after the accepted branch op.
  always_comb begin
    w_state_nxt = r_state;
    w_lc_nxt    = r_lc;
    w_ec_nxt    = r_ec;
    w_p_nxt     = 1'b0;
    w_taken_nxt = 1'b0;
    w_p_en_nxt  = 1'b0;
    w_lc_en_nxt = 1'b0;
    w_ec_en_nxt = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.load) begin
          w_lc_nxt    = bus.lc_in;
          w_ec_nxt    = bus.ec_in;
          w_state_nxt = ST_KERNEL;
        end else if (r_state == ST_DONE) begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_KERNEL: begin
        if (w_brf_cycle) begin
          w_p_en_nxt  = 1'b1;
          w_lc_en_nxt = 1'b1;          // LC is rewritten even when already 0
          if (r_lc != '0) begin
            w_lc_nxt    = r_lc - LCWIDTH'(1);
            w_p_nxt     = 1'b1;
            w_taken_nxt = 1'b1;
          end else begin
            w_ec_en_nxt = 1'b1;
            if (r_ec > ECWIDTH'(1)) begin
              w_ec_nxt    = r_ec - ECWIDTH'(1);
              w_taken_nxt = 1'b1;
              w_state_nxt = ST_EPILOGUE;
            end else begin
              // EC of 0 or 1 means no epilogue stages remain to drain
              w_ec_nxt    = '0;
              w_state_nxt = ST_DONE;
            end
          end
        end
      end

      ST_EPILOGUE: begin
        if (w_brf_cycle) begin
          w_p_en_nxt  = 1'b1;
          w_ec_en_nxt = 1'b1;
          if (r_ec > ECWIDTH'(1)) begin
            w_ec_nxt    = r_ec - ECWIDTH'(1);
            w_taken_nxt = 1'b1;
          end else begin
            w_ec_nxt    = '0;
            w_state_nxt = ST_DONE;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_lc    <= '0;
      r_ec    <= '0;
      r_p     <= 1'b0;
      r_taken <= 1'b0;
      r_p_en  <= 1'b0;
      r_lc_en <= 1'b0;
      r_ec_en <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lc    <= w_lc_nxt;
      r_ec    <= w_ec_nxt;
      r_p     <= w_p_nxt;
      r_taken <= w_taken_nxt;
      r_p_en  <= w_p_en_nxt;
      r_lc_en <= w_lc_en_nxt;
      r_ec_en <= w_ec_en_nxt;
    end
  end

  assign bus.p         = r_p;
  assign bus.taken     = r_taken;
  assign bus.p_enable  = r_p_en;
  assign bus.lc_out    = r_lc;
  assign bus.lc_enable = r_lc_en;
  assign bus.ec_out    = r_ec;
  assign bus.ec_enable = r_ec_en;
  assign bus.busy      = (r_state == ST_KERNEL) | (r_state == ST_EPILOGUE);
  assign bus.done      = (r_state == ST_DONE);

`ifdef BRF_EC_ERR_CHECK_EN
  logic r_err;
  logic w_proto_err;

  // A branch op outside a loop, or a load during a loop, is a protocol
  // violation; the event itself is still ignored by the FSM above.
  assign w_proto_err = (((r_state == ST_IDLE) | (r_state == ST_DONE)) & w_brf_cycle)
                     | (((r_state == ST_KERNEL) | (r_state == ST_EPILOGUE)) & bus.load);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_proto_err) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_brf_ec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brf_ec
//  Description : Directed self-checking bench for brf_ec. Each task drives
//                one scenario and compares the registered outputs, sampled
//                1 ns after the rising edge, against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brf_ec;

  localparam int LCWIDTH = 16;
  localparam int ECWIDTH = 4;
`ifdef BRF_EC_ERR_CHECK_EN
  localparam bit c_err_en = 1'b1;
`else
  localparam bit c_err_en = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  brf_ec_if #(.LCWIDTH(LCWIDTH), .ECWIDTH(ECWIDTH)) bus ();

  brf_ec #(.LCWIDTH(LCWIDTH), .ECWIDTH(ECWIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [LCWIDTH-1:0] lc, input logic [ECWIDTH-1:0] ec);
    bus.load = 1'b1; bus.lc_in = lc; bus.ec_in = ec;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic do_brf();
    bus.op = 1'b1;
    tick();
    bus.op = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({bus.p, bus.p_enable, bus.taken, bus.lc_enable, bus.ec_enable, bus.busy, bus.done, bus.err} !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags got %b exp 00000000", {bus.p, bus.p_enable, bus.taken, bus.lc_enable, bus.ec_enable, bus.busy, bus.done, bus.err}); end
    n_checks++; if (bus.lc_out !== 16'd0 || bus.ec_out !== 4'd0) begin
      n_fail++; $display("FAIL reset_counters got lc=%0d ec=%0d exp lc=0 ec=0", bus.lc_out, bus.ec_out); end
  endtask

  // lc_in=3, ec_in=1: four kernel ops, last one finishes the loop.
  task automatic test_kernel_only();
    logic       exp_p[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       exp_t[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] exp_lc[4] = '{16'd2, 16'd1, 16'd0, 16'd0};
    logic [1:0]  exp_en[4] = '{2'b10, 2'b10, 2'b10, 2'b11};
    do_load(16'd3, 4'd1);
    n_checks++; if (bus.busy !== 1'b1 || bus.lc_out !== 16'd3 || bus.ec_out !== 4'd1 || bus.p_enable !== 1'b0 || bus.lc_enable !== 1'b0) begin
      n_fail++; $display("FAIL kern_load got busy=%b lc=%0d ec=%0d pen=%b lcen=%b exp busy=1 lc=3 ec=1 pen=0 lcen=0", bus.busy, bus.lc_out, bus.ec_out, bus.p_enable, bus.lc_enable); end
    for (int i = 0; i < 4; i++) begin
      do_brf();
      n_checks++; if (bus.p !== exp_p[i] || bus.taken !== exp_t[i] || bus.lc_out !== exp_lc[i] || bus.p_enable !== 1'b1 || {bus.lc_enable, bus.ec_enable} !== exp_en[i]) begin
        n_fail++; $display("FAIL kern_step%0d got p=%b t=%b lc=%0d pen=%b en=%b exp p=%b t=%b lc=%0d pen=1 en=%b", i, bus.p, bus.taken, bus.lc_out, bus.p_enable, {bus.lc_enable, bus.ec_enable}, exp_p[i], exp_t[i], exp_lc[i], exp_en[i]); end
    end
    n_checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL kern_done got done=%b busy=%b exp done=1 busy=0", bus.done, bus.busy); end
    tick();
    n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.p_enable !== 1'b0 || bus.p !== 1'b0 || bus.taken !== 1'b0) begin
      n_fail++; $display("FAIL kern_idle got done=%b busy=%b pen=%b p=%b t=%b exp all 0", bus.done, bus.busy, bus.p_enable, bus.p, bus.taken); end
  endtask

  // lc_in=2, ec_in=3: two kernel ops, then epilogue drains EC to zero.
  task automatic test_epilogue();
    logic       exp_p[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_t[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] exp_ec[5] = '{4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
    logic [1:0] exp_en[5] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b01};
    logic       exp_d[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_load(16'd2, 4'd3);
    for (int i = 0; i < 5; i++) begin
      do_brf();
      n_checks++; if (bus.p !== exp_p[i] || bus.taken !== exp_t[i] || bus.ec_out !== exp_ec[i] || {bus.lc_enable, bus.ec_enable} !== exp_en[i] || bus.done !== exp_d[i] || bus.busy !== !exp_d[i]) begin
        n_fail++; $display("FAIL epi_step%0d got p=%b t=%b ec=%0d en=%b done=%b busy=%b exp p=%b t=%b ec=%0d en=%b done=%b", i, bus.p, bus.taken, bus.ec_out, {bus.lc_enable, bus.ec_enable}, bus.done, bus.busy, exp_p[i], exp_t[i], exp_ec[i], exp_en[i], exp_d[i]); end
    end
    tick();
  endtask

  task automatic test_zero_count();
    do_load(16'd0, 4'd0);
    do_brf();
    n_checks++; if ({bus.p, bus.taken, bus.p_enable, bus.lc_enable, bus.ec_enable, bus.done} !== 6'b001111 || bus.ec_out !== 4'd0) begin
      n_fail++; $display("FAIL zero got p,t,pen,lcen,ecen,done=%b ec=%0d exp 001111 ec=0", {bus.p, bus.taken, bus.p_enable, bus.lc_enable, bus.ec_enable, bus.done}, bus.ec_out); end
    tick();
  endtask

  // running low freezes the loop; a load during KERNEL is ignored while
  // the simultaneous op is processed.
  task automatic test_freeze();
    do_load(16'd5, 4'd2);
    bus.running = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_brf();
      n_checks++; if (bus.p_enable !== 1'b0 || bus.lc_enable !== 1'b0 || bus.lc_out !== 16'd5 || bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL freeze%0d got pen=%b lcen=%b lc=%0d busy=%b exp pen=0 lcen=0 lc=5 busy=1", i, bus.p_enable, bus.lc_enable, bus.lc_out, bus.busy); end
    end
    bus.running = 1'b1;
    do_brf();
    n_checks++; if (bus.lc_out !== 16'd4 || bus.p !== 1'b1 || bus.p_enable !== 1'b1) begin
      n_fail++; $display("FAIL resume got lc=%0d p=%b pen=%b exp lc=4 p=1 pen=1", bus.lc_out, bus.p, bus.p_enable); end
    bus.load = 1'b1; bus.lc_in = 16'd9; bus.ec_in = 4'd7; bus.op = 1'b1;
    tick();
    bus.load = 1'b0; bus.op = 1'b0;
    n_checks++; if (bus.lc_out !== 16'd3 || bus.ec_out !== 4'd2 || bus.p !== 1'b1) begin
      n_fail++; $display("FAIL load_ignored got lc=%0d ec=%0d p=%b exp lc=3 ec=2 p=1", bus.lc_out, bus.ec_out, bus.p); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    do_load(16'd4, 4'd2);
    do_brf();
    do_brf();
    n_checks++; if (bus.lc_out !== 16'd2) begin
      n_fail++; $display("FAIL rst_pre got lc=%0d exp 2", bus.lc_out); end
    reset = 1'b1; bus.op = 1'b1; bus.load = 1'b1; bus.lc_in = 16'd7; bus.ec_in = 4'd5;
    tick();
    reset = 1'b0; bus.load = 1'b0;
    n_checks++; if ({bus.p, bus.p_enable, bus.taken, bus.lc_enable, bus.ec_enable, bus.busy, bus.done, bus.err} !== 8'h00 || bus.lc_out !== 16'd0 || bus.ec_out !== 4'd0) begin
      n_fail++; $display("FAIL rst_mid got flags=%b lc=%0d ec=%0d exp 00000000 lc=0 ec=0", {bus.p, bus.p_enable, bus.taken, bus.lc_enable, bus.ec_enable, bus.busy, bus.done, bus.err}, bus.lc_out, bus.ec_out); end
    tick();
    bus.op = 1'b0;
    n_checks++; if (bus.p_enable !== 1'b0 || bus.lc_enable !== 1'b0 || bus.busy !== 1'b0 || bus.lc_out !== 16'd0) begin
      n_fail++; $display("FAIL idle_op got pen=%b lcen=%b busy=%b lc=%0d exp 0 0 0 0", bus.p_enable, bus.lc_enable, bus.busy, bus.lc_out); end
    do_reset();
  endtask

  task automatic test_err();
    do_brf();
    n_checks++; if (bus.err !== c_err_en) begin
      n_fail++; $display("FAIL err_set got %b exp %b", bus.err, c_err_en); end
    tick(); tick();
    n_checks++; if (bus.err !== c_err_en) begin
      n_fail++; $display("FAIL err_sticky got %b exp %b", bus.err, c_err_en); end
    do_reset();
    n_checks++; if (bus.err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear got %b exp 0", bus.err); end
  endtask

  // Loop completes, then a new load lands in the DONE cycle.
  task automatic test_back_to_back();
    do_load(16'd1, 4'd1);
    do_brf();
    do_brf();
    n_checks++; if (bus.done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done got %b exp 1", bus.done); end
    do_load(16'd2, 4'd1);
    n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.lc_out !== 16'd2 || bus.ec_out !== 4'd1) begin
      n_fail++; $display("FAIL b2b_reload got done=%b busy=%b lc=%0d ec=%0d exp done=0 busy=1 lc=2 ec=1", bus.done, bus.busy, bus.lc_out, bus.ec_out); end
    do_brf();
    n_checks++; if (bus.lc_out !== 16'd1 || bus.p !== 1'b1 || bus.taken !== 1'b1) begin
      n_fail++; $display("FAIL b2b_step got lc=%0d p=%b t=%b exp lc=1 p=1 t=1", bus.lc_out, bus.p, bus.taken); end
    do_reset();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.enable = 1'b1; bus.running = 1'b1; bus.op = 1'b0; bus.load = 1'b0;
    bus.lc_in = '0; bus.ec_in = '0;
    tick();
    test_reset();
    test_kernel_only();
    test_epilogue();
    test_zero_count();
    test_freeze();
    test_reset_mid();
    test_err();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
